// File: rtl/wb_pack_sat_multi_pkg.sv
// Shared definitions for the write-back packer: default widths, FSM state
// encodings and saturation bounds expressed as functions of the output width.
package wb_pack_sat_multi_pkg;

  localparam int DEF_NUM_CH         = 2;
  localparam int DEF_NUM_TERMS      = 5;
  localparam int DEF_IN_W           = 10;
  localparam int DEF_OUT_W          = 8;
  localparam int DEF_BYTES_PER_WORD = 8;
  localparam int DEF_ADDR_W         = 12;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RUN      = 3'd1;
  localparam logic [2:0] ST_DRAIN    = 3'd2;
  localparam logic [2:0] ST_FLUSH_WR = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

  function automatic int sat_max(input int out_w);
    return (1 << (out_w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int out_w);
    return -(1 << (out_w - 1));
  endfunction

endpackage

// File: rtl/wb_sum_sat.sv
// One channel of the write-back datapath: registered sum of NUM_TERMS signed
// partial sums, then a registered clamp to signed OUT_W (ReLU first under WB_RELU_EN).
module wb_sum_sat
  import wb_pack_sat_multi_pkg::*;
#(
  parameter int NUM_TERMS = DEF_NUM_TERMS,
  parameter int IN_W      = DEF_IN_W,
  parameter int OUT_W     = DEF_OUT_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_TERMS*IN_W-1:0]   terms,
  output logic signed [OUT_W-1:0]     sat_out
);

  localparam int ACC_W = IN_W + $clog2(NUM_TERMS);
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(sat_max(OUT_W));
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(sat_min(OUT_W));

  logic signed [ACC_W-1:0] term_ext [NUM_TERMS];
  logic signed [ACC_W-1:0] sum_next;
  logic signed [ACC_W-1:0] acc_reg;
  logic signed [ACC_W-1:0] relu_val;
  logic signed [OUT_W-1:0] sat_next;
  logic signed [OUT_W-1:0] sat_reg;

  // ACC_W leaves room for NUM_TERMS full-scale terms, so the sum never wraps.
  for (genvar gi = 0; gi < NUM_TERMS; gi++) begin : g_ext
    assign term_ext[gi] = ACC_W'($signed(terms[gi*IN_W +: IN_W]));
  end

  always_comb begin
    sum_next = '0;
    for (int i = 0; i < NUM_TERMS; i++) begin
      sum_next = sum_next + term_ext[i];
    end
  end

  always_comb begin
    relu_val = acc_reg;
`ifdef WB_RELU_EN
    if (acc_reg[ACC_W-1]) relu_val = '0;
`endif
    if (relu_val > SAT_HI)      sat_next = SAT_HI[OUT_W-1:0];
    else if (relu_val < SAT_LO) sat_next = SAT_LO[OUT_W-1:0];
    else                        sat_next = relu_val[OUT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg <= '0;
      sat_reg <= '0;
    end else begin
      acc_reg <= sum_next;
      sat_reg <= sat_next;
    end
  end

  assign sat_out = sat_reg;

endmodule

// File: rtl/wb_pack_sat_multi.sv
// Write-back stage: per-channel sum/saturate, pack BYTES_PER_WORD results per
// BRAM word, auto-incrementing addresses, flush of a partial word. Option: WB_RELU_EN.
module wb_pack_sat_multi
  import wb_pack_sat_multi_pkg::*;
#(
  parameter int NUM_CH         = DEF_NUM_CH,
  parameter int NUM_TERMS      = DEF_NUM_TERMS,
  parameter int IN_W           = DEF_IN_W,
  parameter int OUT_W          = DEF_OUT_W,
  parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD,
  parameter int ADDR_W         = DEF_ADDR_W
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [NUM_CH*ADDR_W-1:0]          base_addr,
  input  logic                              in_valid,
  input  logic [NUM_CH*NUM_TERMS*IN_W-1:0]  sum_in,
  input  logic                              flush,
  output logic                              in_ready,
  output logic                              we,
  output logic [NUM_CH*ADDR_W-1:0]          addr,
  output logic [NUM_CH*OUT_W*BYTES_PER_WORD-1:0] din,
  output logic                              done
);

  localparam int DATA_W = OUT_W * BYTES_PER_WORD;
  localparam int IDX_W  = $clog2(BYTES_PER_WORD);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  logic [2:0]       state_reg;
  logic             drain_cnt_reg;
  logic             v1_reg;
  logic             v2_reg;
  logic [IDX_W-1:0] byte_idx_reg;
  logic [IDX_W-1:0] byte_idx_next;
  logic             we_reg;
  logic             take;
  logic             lane_last;
  logic             drain_end;
  logic             flush_wr_go;
  logic             word_write;

  assign in_ready = (state_reg == ST_RUN);
  assign done     = (state_reg == ST_DONE);
  assign we       = we_reg;
  assign take     = in_valid && in_ready;

  assign lane_last     = v2_reg && (byte_idx_reg == LAST_IDX);
  assign byte_idx_next = !v2_reg  ? byte_idx_reg :
                         lane_last ? '0 : byte_idx_reg + IDX_W'(1);

  // The drain decision looks at the lane being written on the same edge, so the
  // last in-flight beat is already counted when choosing FLUSH_WR or DONE.
  assign drain_end   = (state_reg == ST_DRAIN) && drain_cnt_reg;
  assign flush_wr_go = drain_end && (byte_idx_next != '0);
  assign word_write  = lane_last || flush_wr_go;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      drain_cnt_reg <= 1'b0;
      v1_reg        <= 1'b0;
      v2_reg        <= 1'b0;
      byte_idx_reg  <= '0;
      we_reg        <= 1'b0;
    end else if (start) begin
      state_reg     <= ST_RUN;
      drain_cnt_reg <= 1'b0;
      v1_reg        <= 1'b0;
      v2_reg        <= 1'b0;
      byte_idx_reg  <= '0;
      we_reg        <= 1'b0;
    end else begin
      v1_reg       <= take;
      v2_reg       <= v1_reg;
      byte_idx_reg <= word_write ? '0 : byte_idx_next;
      we_reg       <= word_write;
      case (state_reg)
        ST_RUN: begin
          if (flush) begin
            state_reg     <= ST_DRAIN;
            drain_cnt_reg <= 1'b0;
          end
        end
        ST_DRAIN: begin
          drain_cnt_reg <= 1'b1;
          if (drain_cnt_reg) state_reg <= flush_wr_go ? ST_FLUSH_WR : ST_DONE;
        end
        ST_FLUSH_WR: state_reg <= ST_DONE;
        ST_DONE:     state_reg <= ST_IDLE;
        default:     state_reg <= ST_IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [OUT_W-1:0]  sat_lane;
    logic [DATA_W-1:0] shadow_reg;
    logic [DATA_W-1:0] word_next;
    logic [DATA_W-1:0] din_reg;
    logic [ADDR_W-1:0] addr_cnt_reg;
    logic [ADDR_W-1:0] addr_reg;

    wb_sum_sat #(
      .NUM_TERMS (NUM_TERMS),
      .IN_W      (IN_W),
      .OUT_W     (OUT_W)
    ) u_sum_sat (
      .clk     (clk),
      .rst     (rst),
      .terms   (sum_in[gi*NUM_TERMS*IN_W +: NUM_TERMS*IN_W]),
      .sat_out (sat_lane)
    );

    always_comb begin
      word_next = shadow_reg;
      if (v2_reg) word_next[byte_idx_reg*OUT_W +: OUT_W] = sat_lane;
    end

    // The address counter advances the cycle after we, so addr shows the
    // address actually written while we is high.
    always_ff @(posedge clk) begin
      if (rst) begin
        shadow_reg   <= '0;
        din_reg      <= '0;
        addr_cnt_reg <= '0;
        addr_reg     <= '0;
      end else if (start) begin
        shadow_reg   <= '0;
        addr_cnt_reg <= base_addr[gi*ADDR_W +: ADDR_W];
      end else begin
        if (we_reg) addr_cnt_reg <= addr_cnt_reg + ADDR_W'(1);
        if (word_write) begin
          shadow_reg <= '0;
          din_reg    <= word_next;
          addr_reg   <= addr_cnt_reg;
        end else if (v2_reg) begin
          shadow_reg <= word_next;
        end
      end
    end

    assign din[gi*DATA_W +: DATA_W]  = din_reg;
    assign addr[gi*ADDR_W +: ADDR_W] = addr_reg;
  end

endmodule

// File: tb/tb_wb_pack_sat_multi.sv
// Scoreboard bench for wb_pack_sat_multi: random and directed beats, model-built
// expected writes/done pulses queued at stimulus time and popped by a monitor.
module tb_wb_pack_sat_multi;

  localparam int NUM_CH    = 2;
  localparam int NUM_TERMS = 5;
  localparam int IN_W      = 10;
  localparam int OUT_W     = 8;
  localparam int BPW       = 8;
  localparam int ADDR_W    = 12;
  localparam int DATA_W    = OUT_W * BPW;

  logic                             clk = 1'b0;
  logic                             rst;
  logic                             start;
  logic [NUM_CH*ADDR_W-1:0]         base_addr;
  logic                             in_valid;
  logic [NUM_CH*NUM_TERMS*IN_W-1:0] sum_in;
  logic                             flush;
  logic                             in_ready;
  logic                             we;
  logic [NUM_CH*ADDR_W-1:0]         addr;
  logic [NUM_CH*DATA_W-1:0]         din;
  logic                             done;

  always #5 clk = ~clk;

  wb_pack_sat_multi #(
    .NUM_CH         (NUM_CH),
    .NUM_TERMS      (NUM_TERMS),
    .IN_W           (IN_W),
    .OUT_W          (OUT_W),
    .BYTES_PER_WORD (BPW),
    .ADDR_W         (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .in_valid  (in_valid),
    .sum_in    (sum_in),
    .flush     (flush),
    .in_ready  (in_ready),
    .we        (we),
    .addr      (addr),
    .din       (din),
    .done      (done)
  );

  typedef struct {
    bit                       is_done;
    int                       cyc;
    logic [NUM_CH*ADDR_W-1:0] a;
    logic [NUM_CH*DATA_W-1:0] d;
  } exp_t;

  exp_t exp_q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model state: results gathered so far in the current word.
  int                mcnt;
  logic [DATA_W-1:0] mword [NUM_CH];
  logic [ADDR_W-1:0] maddr [NUM_CH];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int ref_sat(input int total);
    int t;
    t = total;
`ifdef WB_RELU_EN
    if (t < 0) t = 0;
`endif
    if (t > (1 << (OUT_W - 1)) - 1) t = (1 << (OUT_W - 1)) - 1;
    if (t < -(1 << (OUT_W - 1)))    t = -(1 << (OUT_W - 1));
    return t;
  endfunction

  function automatic int pick(input int mode, input int ch, input int t);
    case (mode)
      1: if (ch == 0) return t + 1;
      2: return 511;
      3: return -512;
      4: if (ch == 0) return (t == 0) ? 127 : 0; else return (t == 0) ? -128 : 0;
      5: return (ch == 0) ? -4 : 4;
      default: ;
    endcase
    if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, 60)) - 30;
    return int'($urandom_range(0, 1023)) - 512;
  endfunction

  function automatic void model_clear();
    mcnt = 0;
    for (int ch = 0; ch < NUM_CH; ch++) mword[ch] = '0;
  endfunction

  function automatic void push_word(input int acc_edge);
    exp_t e;
    e.is_done = 1'b0;
    e.cyc     = acc_edge + 2;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      e.a[ch*ADDR_W +: ADDR_W] = maddr[ch];
      e.d[ch*DATA_W +: DATA_W] = mword[ch];
      maddr[ch] = maddr[ch] + 1'b1;
    end
    exp_q.push_back(e);
    model_clear();
  endfunction

  function automatic void push_done(input int at);
    exp_t e;
    e.is_done = 1'b1;
    e.cyc     = at;
    e.a       = '0;
    e.d       = '0;
    exp_q.push_back(e);
  endfunction

  function automatic void model_flush(input int f);
    if (mcnt > 0) begin
      push_word(f);
      push_done(f + 3);
    end else begin
      push_done(f + 2);
    end
  endfunction

  task automatic beat(input int mode, input bit with_flush);
    int total;
    int v;
    logic [DATA_W-1:0] w;
    @(negedge clk);
    start = 1'b0; flush = with_flush; in_valid = 1'b1;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      total = 0;
      for (int t = 0; t < NUM_TERMS; t++) begin
        v = pick(mode, ch, t);
        sum_in[(ch*NUM_TERMS+t)*IN_W +: IN_W] = IN_W'(v);
        total += v;
      end
      w = mword[ch];
      w[mcnt*OUT_W +: OUT_W] = OUT_W'(ref_sat(total));
      mword[ch] = w;
    end
    mcnt++;
    if (mcnt == BPW) push_word(cyc + 1);
    if (with_flush) model_flush(cyc + 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      start = 1'b0; flush = 1'b0; in_valid = 1'b0;
      sum_in = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  task automatic flush_only();
    @(negedge clk);
    start = 1'b0; flush = 1'b1; in_valid = 1'b0;
    model_flush(cyc + 1);
  endtask

  task automatic do_start(input logic [NUM_CH*ADDR_W-1:0] base);
    @(negedge clk);
    start = 1'b1; base_addr = base;
    in_valid = 1'(($urandom_range(0, 1)));
    flush = 1'(($urandom_range(0, 1)));
    model_clear();
    for (int ch = 0; ch < NUM_CH; ch++) maddr[ch] = base[ch*ADDR_W +: ADDR_W];
  endtask

  task automatic do_rst();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  // Monitor: pops one expected event per observed write or done pulse.
  always @(posedge clk) begin
    exp_t e;
    cyc = cyc + 1;
    #1;
    if (we === 1'b1) begin
      $display("write cyc=%0d addr=%h din=%h", cyc, addr, din);
      if (exp_q.size() == 0 || exp_q[0].is_done) begin
        checks++; errors++;
        $display("FAIL unexpected_we: actual we=1 at cycle %0d required none", cyc);
      end else begin
        e = exp_q.pop_front();
        check("we_cycle", 256'(cyc), 256'(e.cyc));
        check("addr", 256'(addr), 256'(e.a));
        check("din", 256'(din), 256'(e.d));
      end
    end
    if (done === 1'b1) begin
      $display("done cyc=%0d", cyc);
      if (exp_q.size() == 0 || !exp_q[0].is_done) begin
        checks++; errors++;
        $display("FAIL unexpected_done: actual done=1 at cycle %0d required none", cyc);
      end else begin
        e = exp_q.pop_front();
        check("done_cycle", 256'(cyc), 256'(e.cyc));
      end
    end
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      checks++; errors++;
      $display("FAIL missing_event: actual none at cycle %0d required %s at %0d",
               cyc, exp_q[0].is_done ? "done" : "we", exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; flush = 1'b0;
    sum_in = '0; base_addr = '0;
    model_clear();
    repeat (3) @(negedge clk);
    check("rst_in_ready", 256'(in_ready), 256'(0));
    check("rst_we", 256'(we), 256'(0));
    check("rst_done", 256'(done), 256'(0));
    check("rst_addr", 256'(addr), 256'(0));
    check("rst_din", 256'(din), 256'(0));
    rst = 1'b0;
    idle(2);

    // Directed: 1..5 on ch0, base 0 / 32, then saturation and pass-through
    do_start({12'd32, 12'd0});
    idle(1);
    check("in_ready_run", 256'(in_ready), 256'(1));
    repeat (8) beat(1, 1'b0);
    beat(2, 1'b0); beat(3, 1'b0); beat(4, 1'b0); beat(5, 1'b0);
    repeat (4) beat(0, 1'b0);
    idle(4);

    // Flush after 3 beats: partial word, then done
    repeat (3) beat(0, 1'b0);
    idle(3);
    flush_only();
    idle(8);
    check("in_ready_idle", 256'(in_ready), 256'(0));

    // Flush after exactly 8 beats: no extra write
    do_start({12'd100, 12'd200});
    repeat (8) beat(0, 1'b0);
    idle(4);
    flush_only();
    idle(8);

    // Address wrap from 0xFFF
    do_start({12'hFFF, 12'hFFF});
    repeat (16) beat(0, 1'b0);
    idle(4);

    // start mid-word drops the partial word
    repeat (5) beat(0, 1'b0);
    do_start({12'd7, 12'd9});
    repeat (8) beat(0, 1'b0);
    idle(4);

    // rst mid-word: no write afterwards
    repeat (5) beat(0, 1'b0);
    do_rst();
    idle(8);

    // Random rounds with gaps and flush (sometimes with a final beat)
    for (int r = 0; r < 12; r++) begin
      do_start({12'($urandom), 12'($urandom)});
      n = int'($urandom_range(0, 30));
      for (int b = 0; b < n; b++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        beat(0, 1'b0);
      end
      if ($urandom_range(0, 1) == 0) beat(0, 1'b1);
      else flush_only();
      idle(8);
    end

    idle(6);
    check("queue_empty", 256'(exp_q.size()), 256'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
